// File: rtl/uart_report_arbiter.sv
// -----------------------------------------------------------------------------
// uart_report_arbiter
//
// Purpose:
//   Lets three report sources share one two-byte UART transmitter. The sources
//   are calculator results, error codes and ASCII echo bytes. Each source has a
//   one-entry pending slot. Slots are granted round-robin, and each granted
//   slot is framed into a 16-bit word:
//     result : res_data
//     error  : {ERR_TAG, 4'h0, err_code}
//     echo   : {ECHO_TAG, echo_data}
//   The arbiter pulses tx_start and then follows tx_busy until the frame is
//   finished. If busy never rises, the grant is abandoned.
//
// Parameters:
//   ERR_TAG    upper byte of error frames
//   ECHO_TAG   upper byte of echo frames
//   BUSY_WAIT  cycles allowed for tx_busy to rise before a grant is abandoned
//              (minimum 2)
//   DROP_W     width of the saturating drop counter
//
// Ports:
//   clock       in   system clock
//   reset_n     in   asynchronous active-low reset
//   res_valid   in   one-cycle pulse, result word available
//   res_data    in   [15:0] result word
//   err_valid   in   one-cycle pulse, error code available
//   err_code    in   [3:0] error code
//   echo_valid  in   one-cycle pulse, echo byte available
//   echo_data   in   [7:0] ASCII byte to echo
//   flush       in   synchronous clear of all pending slots
//   tx_busy     in   transmitter busy
//   tx_start    out  registered one-cycle start pulse to the transmitter
//   tx_data     out  [15:0] frame, held stable from start until the next grant
//   active      out  high whenever the FSM is not idle
//   pending     out  [2:0] slot flags {echo, err, res}
//   drop_count  out  [DROP_W-1:0] saturating count of overwritten slots
//   timeout     out  one-cycle pulse when a grant is abandoned
// -----------------------------------------------------------------------------
module uart_report_arbiter #(
    parameter logic [7:0] ERR_TAG   = 8'hEE,
    parameter logic [7:0] ECHO_TAG  = 8'hEC,
    parameter int         BUSY_WAIT = 4,
    parameter int         DROP_W    = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              res_valid,
    input  logic [15:0]       res_data,
    input  logic              err_valid,
    input  logic [3:0]        err_code,
    input  logic              echo_valid,
    input  logic [7:0]        echo_data,
    input  logic              flush,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [15:0]       tx_data,
    output logic              active,
    output logic [2:0]        pending,
    output logic [DROP_W-1:0] drop_count,
    output logic              timeout
);

    // -------------------------------------------------------------------------
    // Encodings
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_START     = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    // The source identifiers double as round-robin pointer values.
    localparam logic [1:0] SRC_RES  = 2'd0;
    localparam logic [1:0] SRC_ERR  = 2'd1;
    localparam logic [1:0] SRC_ECHO = 2'd2;

    localparam int CNT_W = $clog2(BUSY_WAIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_WAIT - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]       state;
    logic [1:0]       rr_ptr;
    logic [CNT_W-1:0] wait_cnt;

    logic             res_full;
    logic             err_full;
    logic             echo_full;
    logic [15:0]      res_slot;
    logic [3:0]       err_slot;
    logic [7:0]       echo_slot;

    // -------------------------------------------------------------------------
    // Round-robin grant selection
    // -------------------------------------------------------------------------
    // The search starts at the source after the last one granted and follows
    // the order res -> err -> echo -> res. Because the pointer resets to echo,
    // res has first priority after reset.
    logic        grant_en;
    logic [1:0]  grant_src;
    logic [2:0]  grant_vec;
    logic [15:0] grant_frame;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        grant_src = SRC_RES;
        case (rr_ptr)
            SRC_RES: begin
                if      (err_full)  grant_src = SRC_ERR;
                else if (echo_full) grant_src = SRC_ECHO;
                else                grant_src = SRC_RES;
            end
            SRC_ERR: begin
                if      (echo_full) grant_src = SRC_ECHO;
                else if (res_full)  grant_src = SRC_RES;
                else                grant_src = SRC_ERR;
            end
            default: begin
                if      (res_full)  grant_src = SRC_RES;
                else if (err_full)  grant_src = SRC_ERR;
                else                grant_src = SRC_ECHO;
            end
        endcase

        grant_en  = (state == ST_IDLE) && (res_full || err_full || echo_full);
        grant_vec = grant_en ? (3'b001 << grant_src) : 3'b000;
    end

    always_comb begin
        grant_frame = res_slot;
        case (grant_src)
            SRC_ERR:  grant_frame = {ERR_TAG, 4'h0, err_slot};
            SRC_ECHO: grant_frame = {ECHO_TAG, echo_slot};
            default:  grant_frame = res_slot;
        endcase
    end

    // -------------------------------------------------------------------------
    // Drop accounting
    // -------------------------------------------------------------------------
    // A drop is a new value landing on a slot that is still full and is not
    // being granted this cycle. A flush in the same cycle empties the slot
    // first, so that case is a normal capture and is not counted as a drop.
    logic              drop_res;
    logic              drop_err;
    logic              drop_echo;
    logic [1:0]        drop_inc;
    logic [DROP_W+1:0] drop_sum;
    logic [DROP_W-1:0] drop_next;

    always_comb begin
        drop_res  = res_valid  && res_full  && !grant_vec[0] && !flush;
        drop_err  = err_valid  && err_full  && !grant_vec[1] && !flush;
        drop_echo = echo_valid && echo_full && !grant_vec[2] && !flush;
        drop_inc  = 2'(drop_res) + 2'(drop_err) + 2'(drop_echo);
        drop_sum  = {2'b00, drop_count} + (DROP_W + 2)'(drop_inc);
        // Saturate: any carry out of the counter width pins it at all-ones.
        if (drop_sum[DROP_W+1:DROP_W] != 2'b00) begin
            drop_next = '1;
        end else begin
            drop_next = drop_sum[DROP_W-1:0];
        end
    end

    // -------------------------------------------------------------------------
    // Pending slots
    // -------------------------------------------------------------------------
    // A new valid always wins. It sets the flag even when the slot is being
    // granted or flushed in the same cycle, because the granted frame has
    // already been taken from the old slot contents.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: the slot payloads are reset along with the flags so a frame
        // can never carry power-up garbage, and reset behaviour stays fully
        // defined in simulation.
        if (!reset_n) begin
            res_full   <= 1'b0;
            err_full   <= 1'b0;
            echo_full  <= 1'b0;
            res_slot   <= '0;
            err_slot   <= '0;
            echo_slot  <= '0;
            drop_count <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples pre-edge values regardless of order.
            if (res_valid) begin
                res_full <= 1'b1;
                res_slot <= res_data;
            end else if (flush || grant_vec[0]) begin
                res_full <= 1'b0;
            end

            if (err_valid) begin
                err_full <= 1'b1;
                err_slot <= err_code;
            end else if (flush || grant_vec[1]) begin
                err_full <= 1'b0;
            end

            if (echo_valid) begin
                echo_full <= 1'b1;
                echo_slot <= echo_data;
            end else if (flush || grant_vec[2]) begin
                echo_full <= 1'b0;
            end

            drop_count <= drop_next;
        end
    end

    // -------------------------------------------------------------------------
    // Transmit sequencer
    // -------------------------------------------------------------------------
    // IDLE      : grant a slot, latch its frame and raise tx_start.
    // START     : tx_start is high for this one cycle. Busy is not sampled
    //             here, so a transmitter still busy from an earlier frame
    //             cannot be mistaken for acceptance of this one.
    // WAIT_BUSY : wait up to BUSY_WAIT cycles for busy to rise, else abandon.
    // WAIT_DONE : wait for busy to fall.
    // flush never touches this block, so an in-flight frame always completes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            rr_ptr   <= SRC_ECHO;
            wait_cnt <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            timeout  <= 1'b0;
        end else begin
            // Both pulses default low and are raised for a single cycle below.
            tx_start <= 1'b0;
            timeout  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (grant_en) begin
                        tx_data  <= grant_frame;
                        rr_ptr   <= grant_src;
                        tx_start <= 1'b1;
                        state    <= ST_START;
                    end
                end

                ST_START: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT_BUSY;
                end

                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= ST_WAIT_DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        // The frame is lost. Its slot has already been
                        // released and is not restored.
                        timeout <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    if (!tx_busy) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Status outputs
    // -------------------------------------------------------------------------
    assign active  = (state != ST_IDLE);
    assign pending = {echo_full, err_full, res_full};

endmodule

// File: tb/tb_uart_report_arbiter.sv
`timescale 1ns/1ps
module tb_uart_report_arbiter;

    localparam logic [7:0] ERR_TAG   = 8'hEE;
    localparam logic [7:0] ECHO_TAG  = 8'hEC;
    localparam int         BUSY_WAIT = 4;
    localparam int         DROP_W    = 8;

    logic              clock;
    logic              reset_n;
    logic              res_valid;
    logic [15:0]       res_data;
    logic              err_valid;
    logic [3:0]        err_code;
    logic              echo_valid;
    logic [7:0]        echo_data;
    logic              flush;
    logic              tx_busy;
    logic              tx_start;
    logic [15:0]       tx_data;
    logic              active;
    logic [2:0]        pending;
    logic [DROP_W-1:0] drop_count;
    logic              timeout;

    uart_report_arbiter #(
        .ERR_TAG   (ERR_TAG),
        .ECHO_TAG  (ECHO_TAG),
        .BUSY_WAIT (BUSY_WAIT),
        .DROP_W    (DROP_W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .echo_valid (echo_valid),
        .echo_data  (echo_data),
        .flush      (flush),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .active     (active),
        .pending    (pending),
        .drop_count (drop_count),
        .timeout    (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_vec       = 0;
    int          n_miss      = 0;
    int          start_count = 0;
    logic [15:0] sb[$];
    int          busy_len    = 20;
    bit          busy_en     = 1'b1;

    typedef struct {
        logic [1:0]  src;       // 0 res, 1 err, 2 echo
        logic [15:0] data;
        logic [2:0]  exp_pend;  // pending right after capture
        logic [15:0] exp_frame;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse(input logic [1:0] src, input logic [15:0] data);
        case (src)
            2'd0:    begin res_valid  = 1'b1; res_data  = data;       end
            2'd1:    begin err_valid  = 1'b1; err_code  = data[3:0];  end
            default: begin echo_valid = 1'b1; echo_data = data[7:0];  end
        endcase
        tick();
        res_valid  = 1'b0;
        err_valid  = 1'b0;
        echo_valid = 1'b0;
    endtask

    task automatic wait_start(input string name, input int bound);
        int waited;
        waited = 0;
        while (tx_start !== 1'b1 && waited < bound) begin
            tick();
            waited++;
        end
        check(name, 32'(tx_start), 32'd1);
    endtask

    task automatic wait_idle(input string name, input int bound);
        int waited;
        waited = 0;
        while ((active !== 1'b0 || pending !== 3'b000 || tx_busy !== 1'b0) && waited < bound) begin
            tick();
            waited++;
        end
        check(name, {28'd0, active, pending}, 32'd0);
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        res_valid  = 1'b0;
        err_valid  = 1'b0;
        echo_valid = 1'b0;
        flush      = 1'b0;
        sb.delete();
        tick();
        tick();
        check("reset outputs", {2'b00, tx_start, tx_data, active, pending, drop_count, timeout}, 32'd0);
        reset_n = 1'b1;
        tick();
    endtask

    // Scoreboard consumer: every start pulse must match the oldest expected frame.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && tx_start === 1'b1) begin
            start_count++;
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL frame: got %h, want no start (t=%0t)", tx_data, $time);
            end else begin
                check("frame", 32'(tx_data), 32'(sb.pop_front()));
            end
        end
    end

    // Transmitter model: busy from the cycle after tx_start for busy_len cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (tx_start === 1'b1 && busy_en) begin
                @(posedge clock);
                #1 tx_busy = 1'b1;
                repeat (busy_len) @(posedge clock);
                #1 tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        res_valid  = 1'b0;
        res_data   = '0;
        err_valid  = 1'b0;
        err_code   = '0;
        echo_valid = 1'b0;
        echo_data  = '0;
        flush      = 1'b0;
        reset_n    = 1'b0;

        vecs[0] = '{2'd0, 16'h1234, 3'b001, 16'h1234};
        vecs[1] = '{2'd1, 16'h0003, 3'b010, 16'hEE03};
        vecs[2] = '{2'd2, 16'h0041, 3'b100, 16'hEC41};
        vecs[3] = '{2'd1, 16'h000F, 3'b010, 16'hEE0F};
        vecs[4] = '{2'd0, 16'hFFFF, 3'b001, 16'hFFFF};
        vecs[5] = '{2'd2, 16'h0000, 3'b100, 16'hEC00};
        vecs[6] = '{2'd0, 16'h0000, 3'b001, 16'h0000};

        // ---- single transactions: latency, framing, active span ----------
        do_reset();
        foreach (vecs[i]) begin
            sb.push_back(vecs[i].exp_frame);
            pulse(vecs[i].src, vecs[i].data);
            check("lat1 start", 32'(tx_start), 32'd0);
            check("lat1 pending", 32'(pending), 32'(vecs[i].exp_pend));
            tick();
            check("lat2 start", 32'(tx_start), 32'd1);
            check("lat2 pending", 32'(pending), 32'd0);
            repeat (10) tick();
            check("active while busy", 32'(active), 32'd1);
            wait_idle("single idle", 60);
        end

        // ---- simultaneous requests: res, err, echo in order ---------------
        do_reset();
        sb.push_back(16'h00AB);
        sb.push_back(16'hEE03);
        sb.push_back(16'hEC41);
        s0 = start_count;
        res_valid = 1'b1;  res_data  = 16'h00AB;
        err_valid = 1'b1;  err_code  = 4'h3;
        echo_valid = 1'b1; echo_data = 8'h41;
        tick();
        res_valid = 1'b0; err_valid = 1'b0; echo_valid = 1'b0;
        check("simul pending", 32'(pending), 32'h7);
        wait_idle("simul idle", 200);
        check("simul starts", 32'(start_count - s0), 32'd3);
        check("simul drops", 32'(drop_count), 32'd0);
        check("simul sb empty", 32'(sb.size()), 32'd0);

        // ---- valid in the same cycle its slot is granted ------------------
        sb.push_back(16'h1111);
        sb.push_back(16'h2222);
        pulse(2'd0, 16'h1111);
        pulse(2'd0, 16'h2222);
        check("regrant start", 32'(tx_start), 32'd1);
        check("regrant pending", 32'(pending), 32'h1);
        check("regrant drops", 32'(drop_count), 32'd0);
        wait_idle("regrant idle", 200);
        check("regrant drops end", 32'(drop_count), 32'd0);

        // ---- overwrite and saturation -------------------------------------
        do_reset();
        sb.push_back(16'h5555);
        pulse(2'd0, 16'h5555);
        repeat (5) tick();
        pulse(2'd2, 16'h0031);
        pulse(2'd2, 16'h0032);
        sb.push_back(16'hEC32);
        check("overwrite drop", 32'(drop_count), 32'd1);
        wait_idle("overwrite idle", 100);
        check("overwrite drop end", 32'(drop_count), 32'd1);

        busy_len = 350;
        sb.push_back(16'h0001);
        pulse(2'd0, 16'h0001);
        repeat (5) tick();
        echo_valid = 1'b1;
        for (int i = 0; i <= 300; i++) begin
            echo_data = 8'(i);
            tick();
        end
        echo_valid = 1'b0;
        // 1 earlier drop + 300 overwrites saturates; last byte is 300 mod 256.
        check("saturated drops", 32'(drop_count), 32'hFF);
        check("saturated busy", 32'(active), 32'd1);
        sb.push_back(16'hEC2C);
        wait_idle("saturate idle", 800);
        check("saturated hold", 32'(drop_count), 32'hFF);
        busy_len = 20;

        // ---- fairness: res and err keep requesting ------------------------
        do_reset();
        busy_len = 3;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) sb.push_back(16'hA000 + 16'(i / 2));
            else            sb.push_back({ERR_TAG, 4'h0, 4'(i / 2 + 1)});
        end
        res_valid = 1'b1; res_data = 16'hA000;
        err_valid = 1'b1; err_code = 4'h1;
        tick();
        res_valid = 1'b0; err_valid = 1'b0;
        for (int g = 0; g < 8; g++) begin
            wait_start("fair start", 40);
            if (g < 6) begin
                if (g % 2 == 0) pulse(2'd0, 16'hA000 + 16'(g / 2 + 1));
                else            pulse(2'd1, 16'(g / 2 + 2));
            end else begin
                tick();
            end
        end
        wait_idle("fair idle", 60);
        check("fair sb empty", 32'(sb.size()), 32'd0);
        check("fair drops", 32'(drop_count), 32'd0);
        busy_len = 20;

        // ---- timeout: busy never rises ------------------------------------
        do_reset();
        busy_en = 1'b0;
        sb.push_back(16'hAAAA);
        sb.push_back(16'hEE05);
        res_valid = 1'b1; res_data = 16'hAAAA;
        err_valid = 1'b1; err_code = 4'h5;
        tick();
        res_valid = 1'b0; err_valid = 1'b0;
        wait_start("timeout first start", 10);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("timeout early", 32'(timeout), 32'd0);
        end
        tick();
        check("timeout pulse", 32'(timeout), 32'd1);
        check("timeout idle", 32'(active), 32'd0);
        tick();
        check("timeout regrant", 32'(tx_start), 32'd1);
        check("timeout one cycle", 32'(timeout), 32'd0);
        check("timeout pending", 32'(pending), 32'd0);
        wait_idle("timeout idle", 40);
        busy_en = 1'b1;

        // ---- async reset during WAIT_DONE ---------------------------------
        do_reset();
        sb.push_back(16'h7777);
        pulse(2'd0, 16'h7777);
        wait_start("reset start", 10);
        repeat (4) tick();
        pulse(2'd2, 16'h0055);
        check("pre-reset active", 32'(active), 32'd1);
        check("pre-reset pending", 32'(pending), 32'h4);
        #2 reset_n = 1'b0;
        #1;
        check("async reset outputs", {2'b00, tx_start, tx_data, active, pending, drop_count, timeout}, 32'd0);
        tick();
        reset_n = 1'b1;
        s0 = start_count;
        wait_idle("post-reset idle", 60);
        check("post-reset no start", 32'(start_count - s0), 32'd0);

        // ---- flush during WAIT_DONE ---------------------------------------
        sb.push_back(16'h1357);
        pulse(2'd0, 16'h1357);
        wait_start("flush start", 10);
        repeat (4) tick();
        res_valid = 1'b1;  res_data  = 16'h2468;
        err_valid = 1'b1;  err_code  = 4'h9;
        echo_valid = 1'b1; echo_data = 8'h77;
        tick();
        res_valid = 1'b0; err_valid = 1'b0; echo_valid = 1'b0;
        check("flush pre pending", 32'(pending), 32'h7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush pending", 32'(pending), 32'd0);
        check("flush active", 32'(active), 32'd1);
        s0 = start_count;
        wait_idle("flush idle", 60);
        repeat (10) tick();
        check("flush no start", 32'(start_count - s0), 32'd0);

        // flush and a valid in the same cycle: the valid wins.
        sb.push_back(16'hEC5A);
        flush = 1'b1;
        echo_valid = 1'b1; echo_data = 8'h5A;
        tick();
        flush = 1'b0; echo_valid = 1'b0;
        check("flush+valid pending", 32'(pending), 32'h4);
        wait_idle("flush+valid idle", 60);
        check("final sb empty", 32'(sb.size()), 32'd0);
        check("final drops", 32'(drop_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
